// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet datapath blocks: arbiter state encoding and
// index-width helper.
package eth_pkg;

  localparam logic [1:0] ARB_STATE_IDLE   = 2'd0;
  localparam logic [1:0] ARB_STATE_ACTIVE = 2'd1;
  localparam logic [1:0] ARB_STATE_ABORT  = 2'd2;

  localparam int unsigned STALL_CNT_W = 8;

  // Width of an index into n ports; a single port still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin priority encoder: first requester strictly after `last`,
// wrapping modulo N, so the previous owner has the lowest priority.
module arb_rr_select
  import eth_pkg::*;
#(
  parameter int N = 2,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic         valid
);

  int unsigned j;
  logic [W-1:0] jw;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    jw    = '0;
    for (int k = 1; k <= N; k++) begin
      j  = (32'(last) + 32'(k)) % 32'(N);
      jw = W'(j);
      if (!valid && req[jw]) begin
        idx   = jw;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Frame-level round-robin arbiter in front of the MAC TX port, with a stall watchdog
// that terminates a starved frame with a bad-frame beat.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int S_COUNT       = 2,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [S_COUNT*8-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]   s_axis_tvalid,
  output logic [S_COUNT-1:0]   s_axis_tready,
  input  logic [S_COUNT-1:0]   s_axis_tlast,
  input  logic [S_COUNT-1:0]   s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [S_COUNT-1:0]   grant,
  output logic                 busy,
  output logic                 stall_abort
);

  localparam int CL_S_COUNT = idx_width(S_COUNT);

  logic [1:0]             state_q, state_d;
  logic [S_COUNT-1:0]     grant_q, grant_d;
  logic [CL_S_COUNT-1:0]  last_grant_q, last_grant_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d, stall_cnt_inc;
  logic [7:0]             tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   tuser_q, tuser_d;
  logic                   stall_abort_q, stall_abort_d;

  logic                   ld;
  logic [7:0]             src_data [S_COUNT];
  logic                   src_valid, src_last, src_user;
  logic [CL_S_COUNT-1:0]  sel_idx;
  logic                   sel_valid;

  arb_rr_select #(
    .N(S_COUNT),
    .W(CL_S_COUNT)
  ) u_select (
    .req  (s_axis_tvalid),
    .last (last_grant_q),
    .idx  (sel_idx),
    .valid(sel_valid)
  );

  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      src_data[i] = s_axis_tdata[8*i +: 8];
    end
  end

  // last_grant_q holds the current owner's index whenever a frame is in progress.
  assign src_valid = s_axis_tvalid[last_grant_q];
  assign src_last  = s_axis_tlast[last_grant_q];
  assign src_user  = s_axis_tuser[last_grant_q];

  assign ld = m_axis_tready | ~tvalid_q;

  assign stall_cnt_inc = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    stall_cnt_d   = stall_cnt_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    stall_abort_d = 1'b0;
    s_axis_tready = '0;

    // Output register drains by default; a load below overrides.
    if (ld) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      ARB_STATE_IDLE: begin
        stall_cnt_d = '0;
        if (sel_valid) begin
          grant_d      = S_COUNT'(1) << sel_idx;
          last_grant_d = sel_idx;
          state_d      = ARB_STATE_ACTIVE;
        end
      end

      ARB_STATE_ACTIVE: begin
        s_axis_tready = grant_q & {S_COUNT{ld}};
        if (ld && src_valid) begin
          tdata_d     = src_data[last_grant_q];
          tvalid_d    = 1'b1;
          tlast_d     = src_last;
          tuser_d     = src_user;
          stall_cnt_d = '0;
          if (src_last) begin
            grant_d = '0;
            state_d = ARB_STATE_IDLE;
          end
        end else if (ld) begin
          // Only starvation with the MAC ready counts; MAC backpressure never does.
          if (stall_cnt_inc == STALL_CNT_W'(STALL_TIMEOUT)) begin
            tdata_d       = 8'h00;
            tvalid_d      = 1'b1;
            tlast_d       = 1'b1;
            tuser_d       = 1'b1;
            stall_abort_d = 1'b1;
            stall_cnt_d   = '0;
            state_d       = ARB_STATE_ABORT;
          end else begin
            stall_cnt_d = stall_cnt_inc;
          end
        end
      end

      ARB_STATE_ABORT: begin
        // Swallow the rest of the broken frame; grant stays with the owner.
        s_axis_tready = grant_q;
        if (src_valid && src_last) begin
          grant_d = '0;
          state_d = ARB_STATE_IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = ARB_STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_STATE_IDLE;
      grant_q       <= '0;
      last_grant_q  <= CL_S_COUNT'(S_COUNT - 1);
      stall_cnt_q   <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      stall_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      stall_cnt_q   <= stall_cnt_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      stall_abort_q <= stall_abort_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign grant         = grant_q;
  assign busy          = (state_q != ARB_STATE_IDLE);
  assign stall_abort   = stall_abort_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Scoreboard bench for eth_tx_arb: sources are driven from per-port beat queues, the
// expected MAC-side beats are queued by the stimulus and checked by a monitor.
module tb_eth_tx_arb;

  localparam int S  = 2;
  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [S*8-1:0] s_axis_tdata;
  logic [S-1:0]   s_axis_tvalid;
  logic [S-1:0]   s_axis_tready;
  logic [S-1:0]   s_axis_tlast;
  logic [S-1:0]   s_axis_tuser;
  logic [7:0]     m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic           m_axis_tuser;
  logic [S-1:0]   grant;
  logic           busy;
  logic           stall_abort;

  eth_tx_arb #(
    .S_COUNT(S),
    .STALL_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .grant        (grant),
    .busy         (busy),
    .stall_abort  (stall_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    int         dly;   // cycles of tvalid low before this beat is offered
  } beat_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } exp_t;

  beat_t src_q [S][$];
  exp_t  exp_q [$];
  exp_t  mon_e;

  int errors  = 0;
  int checks  = 0;
  int n_abort = 0;
  bit chk_en  = 1'b1;
  bit toggle  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input int p, input logic [7:0] d, input logic l, input logic u,
                      input int dly);
    beat_t b;
    b.data = d;
    b.last = l;
    b.user = u;
    b.dly  = dly;
    src_q[p].push_back(b);
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l, input logic u);
    exp_t e;
    e.d = d;
    e.l = l;
    e.u = u;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input logic [S-1:0] g, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (grant == g) break;
    end
    check(name, 32'(grant), 32'(g));
  endtask

  task automatic wait_done(input int budget, input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
             !busy && !m_axis_tvalid;
    end
    check(name, 32'(done), 32'd1);
  endtask

  // Source driver and MAC ready generator.
  initial begin
    bit    acc [S];
    beat_t b;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      for (int p = 0; p < S; p++) acc[p] = s_axis_tvalid[p] & s_axis_tready[p];
      @(posedge clk);
      #1;
      m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
      for (int p = 0; p < S; p++) begin
        if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (src_q[p].size() > 0) begin
          b = src_q[p][0];
          if (b.dly > 0) begin
            b.dly--;
            src_q[p][0] = b;
            s_axis_tvalid[p] = 1'b0;
          end else begin
            s_axis_tvalid[p]      = 1'b1;
            s_axis_tdata[p*8 +: 8] = b.data;
            s_axis_tlast[p]       = b.last;
            s_axis_tuser[p]       = b.user;
          end
        end else begin
          s_axis_tvalid[p] = 1'b0;
        end
      end
    end
  end

  // Monitor: every MAC-side transfer is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (stall_abort) n_abort++;
      if (chk_en && m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %02h last %0b user %0b, expected none",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", 32'(m_axis_tdata), 32'(mon_e.d));
          check("beat_last", 32'(m_axis_tlast), 32'(mon_e.l));
          check("beat_user", 32'(m_axis_tuser), 32'(mon_e.u));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int ab0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_m_tlast_tuser", 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
    check("rst_grant_busy", 32'({grant, busy, stall_abort}), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Two simultaneous 4-byte frames: port 0 wins first, no interleave.
    for (int i = 0; i < 4; i++) send(0, 8'(8'h11 + i), (i == 3), 1'b0, 0);
    for (int i = 0; i < 4; i++) send(1, 8'(8'h21 + i), (i == 3), 1'b0, 0);
    for (int i = 0; i < 4; i++) expect_beat(8'(8'h11 + i), (i == 3), 1'b0);
    for (int i = 0; i < 4; i++) expect_beat(8'(8'h21 + i), (i == 3), 1'b0);
    wait_grant(2'b01, 10, "t1_grant_p0");
    wait_grant(2'b10, 20, "t1_grant_p1");
    wait_done(60, "t1_done");
    check("t1_no_abort", 32'(n_abort), 32'd0);

    // Three back-to-back frames per port: strict alternation P0,P1,...
    for (int f = 0; f < 3; f++) begin
      send(0, 8'(8'h30 + 2*f), 1'b0, 1'b0, 0);
      send(0, 8'(8'h31 + 2*f), 1'b1, 1'b0, 0);
      send(1, 8'(8'hB0 + 2*f), 1'b0, 1'b0, 0);
      send(1, 8'(8'hB1 + 2*f), 1'b1, 1'b0, 0);
    end
    for (int f = 0; f < 3; f++) begin
      expect_beat(8'(8'h30 + 2*f), 1'b0, 1'b0);
      expect_beat(8'(8'h31 + 2*f), 1'b1, 1'b0);
      expect_beat(8'(8'hB0 + 2*f), 1'b0, 1'b0);
      expect_beat(8'(8'hB1 + 2*f), 1'b1, 1'b0);
    end
    wait_done(100, "t2_done");

    // MAC ready toggling: order kept, backpressure never aborts.
    toggle = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(0, 8'(8'h41 + i), (i == 5), 1'b0, 0);
      expect_beat(8'(8'h41 + i), (i == 5), 1'b0);
    end
    wait_done(100, "t3_done");
    toggle = 1'b0;
    check("t3_no_abort", 32'(n_abort), 32'd0);

    // Starved for TIMEOUT-1 cycles, then a beat arrives: no abort.
    send(1, 8'h51, 1'b0, 1'b0, 0);
    send(1, 8'h52, 1'b0, 1'b0, TO - 1);
    send(1, 8'h53, 1'b1, 1'b0, 0);
    expect_beat(8'h51, 1'b0, 1'b0);
    expect_beat(8'h52, 1'b0, 1'b0);
    expect_beat(8'h53, 1'b1, 1'b0);
    wait_done(60, "t4_done");
    check("t4_no_abort", 32'(n_abort), 32'd0);

    // Starved for TIMEOUT cycles: abort beat, rest of frame drained.
    ab0 = n_abort;
    send(0, 8'hAA, 1'b0, 1'b0, 0);
    send(0, 8'hBB, 1'b0, 1'b0, 0);
    send(0, 8'hCC, 1'b0, 1'b0, TO);
    send(0, 8'hDD, 1'b1, 1'b0, 0);
    expect_beat(8'hAA, 1'b0, 1'b0);
    expect_beat(8'hBB, 1'b0, 1'b0);
    expect_beat(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall_abort) break;
    end
    check("t5_abort_pulse", 32'(stall_abort), 32'd1);
    check("t5_grant_held", 32'({grant, busy}), 32'({2'b01, 1'b1}));
    wait_done(60, "t5_done");
    check("t5_abort_count", 32'(n_abort - ab0), 32'd1);
    check("t5_grant_clear", 32'(grant), 32'd0);

    // Source bad-frame flag forwarded without an abort.
    ab0 = n_abort;
    send(1, 8'h71, 1'b0, 1'b0, 0);
    send(1, 8'h72, 1'b0, 1'b0, 0);
    send(1, 8'h73, 1'b1, 1'b1, 0);
    expect_beat(8'h71, 1'b0, 1'b0);
    expect_beat(8'h72, 1'b0, 1'b0);
    expect_beat(8'h73, 1'b1, 1'b1);
    wait_done(60, "t6_done");
    check("t6_no_abort", 32'(n_abort - ab0), 32'd0);

    // Reset mid-frame: everything clears and port 0 wins the next arbitration.
    chk_en = 1'b0;
    for (int i = 0; i < 6; i++) send(0, 8'(8'h61 + i), (i == 5), 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tdata == 8'h63) break;
    end
    check("t7_reached_byte3", 32'(m_axis_tdata), 32'h63);
    @(posedge clk);
    #2;
    rst = 1'b1;
    src_q[0].delete();
    src_q[1].delete();
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t7_m_axis_clear", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}),
          32'd0);
    check("t7_state_clear", 32'({grant, busy, stall_abort}), 32'd0);
    check("t7_s_tready_clear", 32'(s_axis_tready), 32'd0);
    chk_en = 1'b1;
    send(1, 8'h81, 1'b0, 1'b0, 0);
    send(1, 8'h82, 1'b1, 1'b0, 0);
    send(0, 8'h91, 1'b0, 1'b0, 0);
    send(0, 8'h92, 1'b1, 1'b0, 0);
    expect_beat(8'h91, 1'b0, 1'b0);
    expect_beat(8'h92, 1'b1, 1'b0);
    expect_beat(8'h81, 1'b0, 1'b0);
    expect_beat(8'h82, 1'b1, 1'b0);
    wait_grant(2'b01, 10, "t7_grant_p0_first");
    wait_done(60, "t7_done");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Frame-level round-robin arbiter that shares one MAC TX AXI-stream input (8-bit, tuser = bad frame) among S_COUNT requesters, e.g. host CPU path, UDP engine and ARP responder.
- Once a port is granted, its whole frame passes through unbroken. Frames are never interleaved.
- Includes a stall watchdog. If a granted source starves the MAC mid-frame, the frame is terminated with tuser=1 instead of underflowing the MAC.
- Sits directly in front of the RMII/MII MAC TX port, in the MAC clock domain.

Parameters:
- S_COUNT, 2, number of source ports (2..8).
- STALL_TIMEOUT, 16, number of consecutive starved cycles mid-frame before abort (1..255).

Ports:
- clk  in  1  MAC TX clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  S_COUNT*8  packed source data; port i occupies bits [8i+7:8i].
- s_axis_tvalid  in  S_COUNT  per-port valid.
- s_axis_tready  out  S_COUNT  per-port ready.
- s_axis_tlast  in  S_COUNT  per-port end of frame.
- s_axis_tuser  in  S_COUNT  per-port bad-frame flag.
- m_axis_tdata  out  8  to MAC.
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- m_axis_tuser  out  1
- grant  out  S_COUNT  one-hot owner of the current frame; 0 when idle.
- busy  out  1  a frame is in progress (state != IDLE).
- stall_abort  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- Reset values: all outputs 0 (m_axis_*, s_axis_tready, grant, busy, stall_abort); last_grant = S_COUNT-1, so port 0 wins first; stall counter = 0; state = IDLE. A reset mid-frame drops the partial frame silently. No tlast is emitted.
- Output stage:
  - Single register stage.
  - Load enable: ld = m_axis_tready | ~m_axis_tvalid.
  - m_axis_tvalid clears after a transfer when nothing is loaded.
  - Latency from source transfer to m_axis_tvalid is 1 cycle.
- State IDLE:
  - s_axis_tready = 0 on all ports.
  - If any s_axis_tvalid is set, pick the first requesting port searching upward from last_grant+1, wrapping modulo S_COUNT.
  - Set grant one-hot, set last_grant to that index, go to ACTIVE.
  - The first beat is accepted no earlier than the following cycle (1-cycle arbitration latency).
  - Ports that are not requesting are skipped.
- State ACTIVE:
  - Only s_axis_tready[g] = ld; all others are 0.
  - A beat transfers when s_axis_tvalid[g] & ld; it is copied into the output register with tdata/tlast/tuser unchanged.
  - On a transfer with tlast: clear grant, go to IDLE. Back-to-back frames therefore have at least 1 idle cycle between them at the source side.
- Stall counter (ACTIVE only):
  - Increments on cycles where ld=1 and s_axis_tvalid[g]=0.
  - Clears on any source transfer.
  - Saturates; 8-bit.
- Watchdog abort (stall counter reaches STALL_TIMEOUT):
  - Go to ABORT.
  - Pulse stall_abort for 1 cycle.
  - Load the output register with tdata=0x00, tlast=1, tuser=1 (needs ld=1, which is guaranteed by the counting condition).
- State ABORT:
  - Output register no longer fed from this frame.
  - s_axis_tready[g] = 1 (drain mode); beats are discarded.
  - On a discarded beat with tlast: clear grant, go to IDLE.
  - grant stays asserted during the drain.
- Simultaneous events:
  - tvalid rising in the same cycle the counter would hit the timeout: the transfer wins and the counter clears.
  - A request from the previous owner arriving in IDLE with other ports also requesting: the previous owner has lowest priority (fairness).
- m_axis_tready low for any duration never counts toward the timeout, so MAC backpressure is never aborted.
- Source tuser=1 is forwarded unchanged. No extra abort.

Decomposition:
- Shared package eth_pkg:
  - State encoding constants ARB_STATE_IDLE/ACTIVE/ABORT.
  - localparam width helper for index width, CL_S_COUNT = $clog2(S_COUNT).
- One sub-module, arb_rr_select:
  - Combinational round-robin priority encoder.
  - Inputs: request vector, last_grant index.
  - Outputs: grant index, valid.
  - Reused later by the RX fan-out/filter blocks.

Test Plan:
- Port 0 and port 1 both assert a 4-byte frame (0x11..0x14, 0x21..0x24) at cycle 0 with m_axis_tready=1 → m_axis emits 0x11..0x14 with tlast on 0x14, then 0x21..0x24; grant = 01 then 10; no interleave.
- Three back-to-back frames from each of two ports, requesting continuously → order P0,P1,P0,P1,P0,P1.
- P0 frame with m_axis_tready toggled 1010… → byte order preserved; no duplication or loss; stall_abort never asserts.
- STALL_TIMEOUT=4; P0 sends 0xAA,0xBB then drops tvalid for 4 ld cycles → stall_abort pulses once; m_axis emits 0xAA,0xBB,0x00 with tlast=1, tuser=1. P0 then sends 0xCC,0xDD(tlast) → beats consumed, not output; grant clears after 0xDD.
- rst asserted for 1 cycle mid-frame at byte 3 → all outputs 0 next cycle; next arbitration grants port 0 first.
- Source frame with tuser=1 on tlast → forwarded with m_axis_tuser=1; stall_abort stays 0.
